// File: rtl/transpose_buffer_stream.sv
// transpose_buffer_stream: collects DEPTH rows of LANES samples,
// then streams the block out column by column.
module transpose_buffer_stream #(
  parameter  int DATA_WIDTH = 10,
  parameter  int LANES      = 9,
  parameter  int DEPTH      = 8,
  localparam int CW         = $clog2(LANES+1),
  localparam int RW         = $clog2(DEPTH+1)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*DATA_WIDTH-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DEPTH*DATA_WIDTH-1:0] out_data,
  output logic                        out_last,
  output logic [CW-1:0]               out_col,
  output logic [RW-1:0]               row_count
);

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic            wr_en;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH][LANES];

  // State and counter registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= FILL;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  // Next state: flush aborts the block, else fill or drain
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    wr_en   = 1'b0;
    if (flush) begin
      state_d = FILL;
      row_d   = '0;
      col_d   = '0;
    end else begin
      unique case (state_q)
        FILL: begin
          if (in_valid) begin
            wr_en = 1'b1;
            row_d = row_q + RW'(1);
            if (row_q == RW'(DEPTH-1)) begin
              state_d = DRAIN;
              col_d   = '0;
            end
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (col_q == CW'(LANES-1)) begin
              state_d = FILL;
              row_d   = '0;
              col_d   = '0;
            end else begin
              col_d = col_q + CW'(1);
            end
          end
        end
      endcase
    end
  end

  // Row storage: accepted row lands in slot row_q
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int r = 0; r < DEPTH; r++) begin
        for (int j = 0; j < LANES; j++) begin
          mem_q[r][j] <= '0;
        end
      end
    end else if (wr_en) begin
      for (int r = 0; r < DEPTH; r++) begin
        if (row_q == RW'(r)) begin
          for (int j = 0; j < LANES; j++) begin
            mem_q[r][j] <=
              in_data[j*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
    end
  end

  // Outputs: all zero in reset, column select in drain
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_col   = '0;
    row_count = '0;
    out_data  = '0;
    if (!reset) begin
      row_count = row_q;
      unique case (state_q)
        FILL: begin
          in_ready = 1'b1;
        end
        DRAIN: begin
          out_valid = 1'b1;
          out_col   = col_q;
          out_last  = (col_q == CW'(LANES-1));
          for (int j = 0; j < LANES; j++) begin
            if (col_q == CW'(j)) begin
              for (int k = 0; k < DEPTH; k++) begin
                out_data[k*DATA_WIDTH +: DATA_WIDTH] =
                  mem_q[k][j];
              end
            end
          end
        end
      endcase
    end
  end

endmodule
